// File: rtl/bram_sp_arbiter.sv
// bram_sp_arbiter
// Two-requester front end for a single-port block RAM with a registered read.
// Round-robin arbitration with a bounded burst allowance; read data is routed
// back to the requester that issued the read, one cycle after acceptance.
module bram_sp_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating increment: the burst counter pins at MAX_BURST instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_MAX) begin
      return CNT_MAX;
    end
    return c + CNT_ONE;
  endfunction

  // Arbitration state: who won last and how many consecutive wins it has had.
  logic             last_grant;
  logic [CNT_W-1:0] burst_cnt;

  logic gnt0_p0;
  logic gnt1_p0;
  logic rd_p0;

  logic vld_p1;
  logic tag_p1;

  // ---- Stage p0: combinational grant and RAM drive in the acceptance cycle ----

  // Pick the winner; the incumbent keeps the port only while its burst allowance lasts.
  always_comb begin
    gnt0_p0 = 1'b0;
    gnt1_p0 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        if (burst_cnt < CNT_MAX) begin
          gnt0_p0 = ~last_grant;
          gnt1_p0 = last_grant;
        end else begin
          gnt0_p0 = last_grant;
          gnt1_p0 = ~last_grant;
        end
      end else begin
        gnt0_p0 = req0_valid;
        gnt1_p0 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0_p0;
  assign req1_ready = gnt1_p0;
  assign rd_p0      = (gnt0_p0 && !req0_we) || (gnt1_p0 && !req1_we);

  // Steer the winner's fields onto the RAM port; idle port is driven to zero.
  always_comb begin
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    if (gnt0_p0) begin
      ram_wea   = req0_we;
      ram_addra = req0_addr;
      ram_dina  = req0_wdata;
    end else if (gnt1_p0) begin
      ram_wea   = req1_we;
      ram_addra = req1_addr;
      ram_dina  = req1_wdata;
    end
  end

  // Update burst bookkeeping on every grant and remember which requester owns the in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      burst_cnt  <= CNT_MAX;
      vld_p1     <= 1'b0;
      tag_p1     <= 1'b0;
    end else begin
      if (gnt0_p0 || gnt1_p0) begin
        if (gnt1_p0 == last_grant) begin
          burst_cnt <= sat_inc(burst_cnt);
        end else begin
          burst_cnt <= CNT_ONE;
        end
        last_grant <= gnt1_p0;
      end
      vld_p1 <= rd_p0;
      tag_p1 <= gnt1_p0;
    end
  end

  // ---- Stage p1: RAM output is valid; route it to the issuing requester ----

  // A reset in the response cycle swallows the response of a read accepted just before it.
  assign rsp0_valid = vld_p1 && !tag_p1 && !rst;
  assign rsp1_valid = vld_p1 &&  tag_p1 && !rst;
  assign rsp0_rdata = ram_douta;
  assign rsp1_rdata = ram_douta;

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Bench for bram_sp_arbiter: two instances (MAX_BURST=2 and MAX_BURST=1), each
// with its own RAM, driven by directed scenarios and random traffic. A per-instance
// reference model predicts grants, RAM drive and read responses; expected
// responses go into a queue that the monitor drains against the DUT outputs.
`timescale 1ns/1ps
module tb_bram_sp_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct {
    int                due;
    int                port;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk  = 0;
  int nfail = 0;

  logic              rst       [2];
  logic              req_valid [2][2];
  logic              req_ready [2][2];
  logic              req_we    [2][2];
  logic [ADDR_W-1:0] req_addr  [2][2];
  logic [DATA_W-1:0] req_wdata [2][2];
  logic              rsp_valid [2][2];
  logic [DATA_W-1:0] rsp_rdata [2][2];
  logic              ram_wea   [2];
  logic [ADDR_W-1:0] ram_addra [2];
  logic [DATA_W-1:0] ram_dina  [2];
  logic [DATA_W-1:0] ram_douta [2];

  // Observations recorded by the monitors for the directed checks
  bit                acc   [2][2];
  int                rcnt  [2][2] = '{default: 0};
  logic [DATA_W-1:0] rlast [2][2];
  int                gseq  [2][1024];
  int                gcnt  [2] = '{default: 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int MB = (k == 0) ? 2 : 1;

    bram_sp_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_BURST(MB)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[k]),
      .req0_valid(req_valid[k][0]),
      .req0_ready(req_ready[k][0]),
      .req0_we   (req_we[k][0]),
      .req0_addr (req_addr[k][0]),
      .req0_wdata(req_wdata[k][0]),
      .rsp0_valid(rsp_valid[k][0]),
      .rsp0_rdata(rsp_rdata[k][0]),
      .req1_valid(req_valid[k][1]),
      .req1_ready(req_ready[k][1]),
      .req1_we   (req_we[k][1]),
      .req1_addr (req_addr[k][1]),
      .req1_wdata(req_wdata[k][1]),
      .rsp1_valid(rsp_valid[k][1]),
      .rsp1_rdata(rsp_rdata[k][1]),
      .ram_wea   (ram_wea[k]),
      .ram_addra (ram_addra[k]),
      .ram_dina  (ram_dina[k]),
      .ram_douta (ram_douta[k])
    );

    // Single-port RAM with registered read (read-first)
    logic [DATA_W-1:0] mem [32] = '{default: '0};
    always @(posedge clk) begin
      if (ram_wea[k]) mem[ram_addra[k]] <= ram_dina[k];
      ram_douta[k] <= mem[ram_addra[k]];
    end

    // Reference model and scoreboard monitor
    exp_t              q[$];
    logic [DATA_W-1:0] shadow [32];
    int                lastg;
    int                run;

    initial begin
      int g;
      bit ev;
      logic [ADDR_W+DATA_W:0] ebus;
      lastg = 1;
      run   = MB;
      for (int i = 0; i < 32; i++) shadow[i] = '0;
      forever begin
        @(negedge clk);
        if (rst[k]) begin
          q.delete();
          lastg = 1;
          run   = MB;
        end
        // responses owed this cycle
        for (int r = 0; r < 2; r++) begin
          ev = (q.size() > 0) && (q[0].due == cyc) && (q[0].port == r);
          chk($sformatf("i%0d rsp%0d_valid", k, r), 64'(rsp_valid[k][r]), 64'(ev));
          if (ev) chk($sformatf("i%0d rsp%0d_rdata", k, r), 64'(rsp_rdata[k][r]), 64'(q[0].data));
          if (rsp_valid[k][r] === 1'b1) begin
            rcnt[k][r]++;
            rlast[k][r] = rsp_rdata[k][r];
          end
        end
        if (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        // grant decision from the round-robin / burst rules
        g = -1;
        if (!rst[k]) begin
          if (req_valid[k][0] && req_valid[k][1]) g = (run < MB) ? lastg : 1 - lastg;
          else if (req_valid[k][0]) g = 0;
          else if (req_valid[k][1]) g = 1;
        end
        chk($sformatf("i%0d ready0", k), 64'(req_ready[k][0]), 64'(g == 0));
        chk($sformatf("i%0d ready1", k), 64'(req_ready[k][1]), 64'(g == 1));
        ebus = '0;
        if (g >= 0) ebus = {req_we[k][g], req_addr[k][g], req_wdata[k][g]};
        chk($sformatf("i%0d ram_bus", k), 64'({ram_wea[k], ram_addra[k], ram_dina[k]}), 64'(ebus));
        // record what the DUT actually accepted
        for (int r = 0; r < 2; r++) begin
          acc[k][r] = req_valid[k][r] && req_ready[k][r];
          if (acc[k][r] && gcnt[k] < 1024) begin
            gseq[k][gcnt[k]] = r;
            gcnt[k]++;
          end
        end
        // advance the model
        if (g >= 0) begin
          if (!req_we[k][g]) q.push_back('{due: cyc + 1, port: g, data: shadow[req_addr[k][g]]});
          else shadow[req_addr[k][g]] = req_wdata[k][g];
          run   = (g == lastg) ? ((run < MB) ? run + 1 : MB) : 1;
          lastg = g;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setr(input int k, input int r, input bit v, input bit we, input int a,
                      input logic [DATA_W-1:0] d);
    req_valid[k][r] = v;
    req_we[k][r]    = we;
    req_addr[k][r]  = ADDR_W'(a);
    req_wdata[k][r] = d;
  endtask

  task automatic idle(input int k);
    setr(k, 0, 1'b0, 1'b0, 0, '0);
    setr(k, 1, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic do_reset(input int k);
    idle(k);
    rst[k] = 1'b1;
    tick();
    rst[k] = 1'b0;
  endtask

  task automatic rand_run(input int k, input int n);
    for (int c = 0; c < n; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[k][r] || acc[k][r])
          setr(k, r, ($urandom % 4) != 0, 1'($urandom % 2), int'($urandom % 8), $urandom);
      end
      rst[k] = ($urandom % 64) == 0;
      tick();
    end
    rst[k] = 1'b0;
    idle(k);
    tick();
    tick();
  endtask

  initial begin
    int base;
    int b0;
    int b1;
    int e3 [6] = '{0, 0, 1, 1, 0, 0};

    // Reset held two cycles with both requesters valid on both instances
    for (int k = 0; k < 2; k++) begin
      setr(k, 0, 1'b1, 1'b0, 1, '0);
      setr(k, 1, 1'b1, 1'b0, 2, '0);
      rst[k] = 1'b1;
    end
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      idle(k);
      rst[k] = 1'b0;
    end
    tick();

    // Write then immediate read-back of the same address by requester 0
    b0 = rcnt[0][0];
    b1 = rcnt[0][1];
    setr(0, 0, 1'b1, 1'b1, 5, 32'hDEADBEEF);
    tick();
    setr(0, 0, 1'b1, 1'b0, 5, '0);
    tick();
    idle(0);
    tick();
    tick();
    chk("rd_after_wr rsp0 count", 64'(rcnt[0][0] - b0), 64'(1));
    chk("rd_after_wr rsp1 count", 64'(rcnt[0][1] - b1), 64'(0));
    chk("rd_after_wr rdata", 64'(rlast[0][0]), 64'(32'hDEADBEEF));

    // Both contending for 6 cycles with MAX_BURST=2
    do_reset(0);
    base = gcnt[0];
    setr(0, 0, 1'b1, 1'b0, 3, '0);
    setr(0, 1, 1'b1, 1'b0, 4, '0);
    for (int i = 0; i < 6; i++) tick();
    idle(0);
    tick();
    tick();
    chk("burst2 grant count", 64'(gcnt[0] - base), 64'(6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("burst2 grant[%0d]", i), 64'(gseq[0][base + i]), 64'(e3[i]));

    // MAX_BURST=1: preload 11/22, then both read continuously
    setr(1, 0, 1'b1, 1'b1, 1, 32'd11);
    tick();
    setr(1, 0, 1'b1, 1'b1, 2, 32'd22);
    tick();
    do_reset(1);
    base = gcnt[1];
    b0 = rcnt[1][0];
    b1 = rcnt[1][1];
    setr(1, 0, 1'b1, 1'b0, 1, '0);
    setr(1, 1, 1'b1, 1'b0, 2, '0);
    for (int i = 0; i < 8; i++) tick();
    idle(1);
    tick();
    tick();
    for (int i = 0; i < 8; i++)
      chk($sformatf("burst1 grant[%0d]", i), 64'(gseq[1][base + i]), 64'(i % 2));
    chk("burst1 rsp0 count", 64'(rcnt[1][0] - b0), 64'(4));
    chk("burst1 rsp1 count", 64'(rcnt[1][1] - b1), 64'(4));
    chk("burst1 rsp0 data", 64'(rlast[1][0]), 64'(32'd11));
    chk("burst1 rsp1 data", 64'(rlast[1][1]), 64'(32'd22));

    // Reset in the response cycle of a req1 read
    do_reset(0);
    b1 = rcnt[0][1];
    setr(0, 1, 1'b1, 1'b0, 4, '0);
    tick();
    idle(0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    base = gcnt[0];
    setr(0, 0, 1'b1, 1'b0, 3, '0);
    setr(0, 1, 1'b1, 1'b0, 4, '0);
    tick();
    idle(0);
    tick();
    tick();
    chk("rst_mid rsp1 count", 64'(rcnt[0][1] - b1), 64'(0));
    chk("rst_mid first grant", 64'(gseq[0][base]), 64'(0));
    chk("rst_mid grant count", 64'(gcnt[0] - base), 64'(1));

    // req1 alone for 5 cycles, then req0 joins
    do_reset(0);
    base = gcnt[0];
    setr(0, 1, 1'b1, 1'b0, 7, '0);
    for (int i = 0; i < 5; i++) tick();
    setr(0, 0, 1'b1, 1'b0, 6, '0);
    tick();
    idle(0);
    tick();
    tick();
    for (int i = 0; i < 5; i++)
      chk($sformatf("solo grant[%0d]", i), 64'(gseq[0][base + i]), 64'(1));
    chk("join grant", 64'(gseq[0][base + 5]), 64'(0));

    // Random mixed traffic with occasional resets on both instances
    rand_run(0, 400);
    rand_run(1, 300);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
